// File: rtl/prbs_checker.sv
// Receive-side checker for the 16-bit XNOR PRBS (taps 15,13,12,10): self-synchronises,
// declares lock, and counts errors and checked bits while locked.
module prbs_checker #(
    parameter int LOCK_COUNT = 32,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t         state;
    logic [15:0]    s;
    logic [4:0]     fill;
    logic [MW-1:0]  match;
    logic [WW-1:0]  win_cnt;
    logic [EW-1:0]  win_err;

    logic           pred;
    logic           mismatch;
    logic [15:0]    s_din;
    logic [MW-1:0]  match_next;
    logic [EW-1:0]  win_err_next;
    logic           count_bit;

    assign pred         = ~(s[15] ^ s[13] ^ s[12] ^ s[10]);
    assign mismatch     = din ^ pred;
    assign s_din        = {s[14:0], din};
    assign match_next   = match + MW'(1);
    assign win_err_next = win_err + EW'(mismatch);
    assign count_bit    = din_valid && (state == LOCKED);

    // The all-ones register self-predicts under XNOR, so it must never be allowed to lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEARCH;
            s         <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                case (state)
                    SEARCH: begin
                        s <= s_din;
                        if (fill != 5'd16) begin
                            fill <= fill + 5'd1;
                        end else if (mismatch) begin
                            match <= '0;
                        end else if (match_next >= MW'(LOCK_COUNT) && s_din != 16'hFFFF) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            match   <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (match != MW'(LOCK_COUNT)) begin
                            match <= match_next;
                        end
                    end
                    LOCKED: begin
                        // Reference runs free on its own prediction so one bad bit costs one count.
                        s         <= {s[14:0], pred};
                        err_pulse <= mismatch;
                        if (win_err_next >= EW'(ERR_THRESH)) begin
                            state   <= SEARCH;
                            locked  <= 1'b0;
                            fill    <= '0;
                            match   <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WW'(WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err_next;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            if (clear) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (count_bit) begin
                if (bit_count != '1)
                    bit_count <= bit_count + CNT_W'(1);
                if (mismatch && err_count != '1)
                    err_count <= err_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a bench-side generator drives the stream and a
// behavioural expectation model pushes per-cycle expected outputs into a queue.
module tb_prbs_checker;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             clear = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    typedef struct packed {
        logic        locked;
        logic        err_pulse;
        logic [15:0] err_count;
        logic [15:0] bit_count;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] gen;
    int          stuck;
    int          m_cnt, m_win, m_werr;
    logic        m_locked, m_pulse;
    logic [15:0] m_ec, m_bc;

    prbs_checker #(.LOCK_COUNT(32), .WINDOW(64), .ERR_THRESH(8), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        gen      = '0;
        stuck    = 0;
        m_cnt    = 0;
        m_win    = 0;
        m_werr   = 0;
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        m_ec     = '0;
        m_bc     = '0;
        sb_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        clear     = 1'b0;
        din       = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_pulse", 32'(err_pulse), 32'd0);
        checkOutput("rst_errs", 32'(err_count), 32'd0);
        checkOutput("rst_bits", 32'(bit_count), 32'd0);
        reset_n = 1'b1;
    endtask

    // One clock: drive at the falling edge, predict, then compare just after the rising edge.
    task automatic applyStimulus(input logic v, input logic e, input logic c);
        logic nb;
        exp_t x;
        exp_t got;
        @(negedge clk);
        if (v) begin
            nb  = ~(gen[15] ^ gen[13] ^ gen[12] ^ gen[10]);
            gen = {gen[14:0], nb};
            if (stuck == 1)
                din = 1'b1;
            else if (stuck == 2)
                din = 1'b0;
            else
                din = nb ^ e;
        end else begin
            din = 1'($urandom_range(0, 1));
        end
        din_valid = v;
        clear     = c;

        m_pulse = 1'b0;
        if (v) begin
            if (!m_locked) begin
                m_cnt++;
                if (m_cnt == 48 && stuck == 0) begin
                    m_locked = 1'b1;
                    m_win    = 0;
                    m_werr   = 0;
                end
            end else begin
                if (m_bc != 16'hFFFF) m_bc++;
                if (e) begin
                    m_pulse = 1'b1;
                    if (m_ec != 16'hFFFF) m_ec++;
                    m_werr++;
                end
                m_win++;
                if (m_werr >= 8) begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                    m_win    = 0;
                    m_werr   = 0;
                end else if (m_win == 64) begin
                    m_win  = 0;
                    m_werr = 0;
                end
            end
        end
        if (c) begin
            m_ec = '0;
            m_bc = '0;
        end
        x.locked    = m_locked;
        x.err_pulse = m_pulse;
        x.err_count = m_ec;
        x.bit_count = m_bc;
        sb_q.push_back(x);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput("locked", 32'(locked), 32'(got.locked));
        checkOutput("err_pulse", 32'(err_pulse), 32'(got.err_pulse));
        checkOutput("err_count", 32'(err_count), 32'(got.err_count));
        checkOutput("bit_count", 32'(bit_count), 32'(got.bit_count));
    endtask

    initial begin
        int lb;

        // Clean stream from generator reset: lock after the 48th valid bit
        doReset();
        repeat (60) applyStimulus(1'b1, 1'b0, 1'b0);

        // Single inverted bit, then a long clean run
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (1000) applyStimulus(1'b1, 1'b0, 1'b0);

        // Stuck-at-1 and stuck-at-0 never lock
        doReset();
        stuck = 1;
        repeat (500) applyStimulus(1'b1, 1'b0, 1'b0);
        doReset();
        stuck = 2;
        repeat (500) applyStimulus(1'b1, 1'b0, 1'b0);

        // Eight errors inside one window drop lock; clean stream relocks after 48 bits
        doReset();
        repeat (58) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (8) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        repeat (70) applyStimulus(1'b1, 1'b0, 1'b0);

        // Seven errors in each of two adjacent windows must not drop lock
        doReset();
        repeat (48) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 160; i++) begin
            lb = i + 1;
            applyStimulus(1'b1, ((lb >= 51 && lb <= 63) || (lb >= 67 && lb <= 79)) && (lb % 2 == 1), 1'b0);
        end

        // Roughly 50% valid duty on a clean stream
        doReset();
        repeat (400) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Clear beats a same-cycle error; then asynchronous reset while locked
        doReset();
        repeat (55) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_locked", 32'(locked), 32'd0);
        checkOutput("async_errs", 32'(err_count), 32'd0);
        checkOutput("async_bits", 32'(bit_count), 32'd0);
        modelReset();
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
